// File: rtl/clk_period_monitor.sv
// clk_period_monitor
// Measures the period and high time (in clk cycles) of a slow periodic
// signal for every rising-to-rising interval and hands each result over a
// valid/ready handshake. Raises a timeout level when no rising edge arrives
// within TIMEOUT cycles and a sticky overrun flag when an unconsumed result
// is overwritten by a newer one.
module clk_period_monitor #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 0,
  parameter int TIMEOUT     = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  input  logic             meas_ready,
  output logic             timeout,
  output logic             overrun
);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // ---------------------------------------------------------------------------
  localparam longint MAX_CNT = (longint'(1) << CNT_W) - 1;

  generate
    if (SYNC_STAGES < 0 || SYNC_STAGES > 3) begin : g_bad_sync
      $error("clk_period_monitor: SYNC_STAGES must be in 0..3");
    end
    if (TIMEOUT < 2 || longint'(TIMEOUT) > MAX_CNT) begin : g_bad_timeout
      $error("clk_period_monitor: TIMEOUT must be in 2..2^CNT_W-1");
    end
  endgenerate

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    MEAS = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Input path: optional synchroniser, then a one-cycle history for edges
  // ---------------------------------------------------------------------------
  logic sig_s;
  logic prev;
  logic rise;
  logic fall;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign sig_s = sig_in;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q;

      // Shift sig_in through SYNC_STAGES flops; cleared on reset.
      always_ff @(posedge clk) begin
        // NOTE: clocked state always uses non-blocking (<=) so every flop
        // samples its inputs from before the edge, regardless of statement order.
        if (rst) begin
          sync_q <= '0;
        end else begin
          sync_q[0] <= sig_in;
          for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
          end
        end
      end

      assign sig_s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  // Previous synchronised sample; resets high so a signal that is already
  // high when reset releases is not mistaken for a fresh rising edge.
  always_ff @(posedge clk) begin
    if (rst) prev <= 1'b1;
    else     prev <= sig_s;
  end

  assign rise = sig_s & ~prev;
  assign fall = ~sig_s & prev;

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [CNT_W-1:0] high_cnt;
  logic             at_limit;
  logic             capture_high;
  logic             load_result;
  logic             set_timeout;
  logic             clr_timeout;

  assign at_limit = (cnt == TIMEOUT_CNT);

  // State and interval counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state, counter and event decode; en=0 overrides everything.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // can leave one unassigned and infer a latch.
    state_next   = state;
    cnt_next     = cnt;
    capture_high = 1'b0;
    load_result  = 1'b0;
    set_timeout  = 1'b0;
    clr_timeout  = 1'b0;

    if (!en) begin
      state_next = IDLE;
      cnt_next   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_next = ARM;
          cnt_next   = '0;
        end

        ARM: begin
          if (rise) begin
            state_next  = MEAS;
            cnt_next    = CNT_ONE;
            clr_timeout = 1'b1;
          end else if (at_limit) begin
            set_timeout = 1'b1;
            cnt_next    = '0;
          end else begin
            cnt_next = cnt + CNT_ONE;
          end
        end

        MEAS: begin
          capture_high = fall;
          if (rise) begin
            // Back-to-back: this rise closes one interval and opens the next.
            load_result = 1'b1;
            cnt_next    = CNT_ONE;
            clr_timeout = 1'b1;
          end else if (at_limit) begin
            set_timeout = 1'b1;
            state_next  = ARM;
            cnt_next    = '0;
          end else begin
            cnt_next = cnt + CNT_ONE;
          end
        end

        default: begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------

  // Counter value at the falling edge = high time of the current interval.
  always_ff @(posedge clk) begin
    if (rst)               high_cnt <= '0;
    else if (capture_high) high_cnt <= cnt;
  end

  // Result registers and handshake; a new result always wins over an
  // acceptance in the same cycle, and overwriting an unconsumed result
  // marks overrun. period/high_time hold their values across en=0.
  always_ff @(posedge clk) begin
    if (rst) begin
      period     <= '0;
      high_time  <= '0;
      meas_valid <= 1'b0;
      overrun    <= 1'b0;
    end else if (!en) begin
      meas_valid <= 1'b0;
      overrun    <= 1'b0;
    end else if (load_result) begin
      period     <= cnt;
      high_time  <= high_cnt;
      meas_valid <= 1'b1;
      if (meas_valid && !meas_ready) overrun <= 1'b1;
    end else if (meas_valid && meas_ready) begin
      meas_valid <= 1'b0;
    end
  end

  // Timeout level: set when the counter reaches TIMEOUT, cleared by a rise.
  always_ff @(posedge clk) begin
    if (rst)              timeout <= 1'b0;
    else if (!en)         timeout <= 1'b0;
    else if (set_timeout) timeout <= 1'b1;
    else if (clr_timeout) timeout <= 1'b0;
  end

endmodule

// File: tb/tb_clk_period_monitor.sv
// Testbench for clk_period_monitor. Two instances (SYNC_STAGES 0 and 2,
// TIMEOUT 20) see identical stimulus. A timestamp-based reference model
// predicts every output each cycle and pushes each accepted result into a
// per-instance queue; a separate monitor pops and compares on every
// valid&&ready handshake the DUT presents.
module tb_clk_period_monitor;

  localparam int CNT_W = 16;
  localparam int TMO   = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic en;
  logic sig_in;
  logic meas_ready;

  logic [CNT_W-1:0] period0, high0, period2, high2;
  logic             valid0, tmo0, ovr0, valid2, tmo2, ovr2;

  clk_period_monitor #(.CNT_W(CNT_W), .SYNC_STAGES(0), .TIMEOUT(TMO)) u_dut0 (
    .clk(clk), .rst(rst), .en(en), .sig_in(sig_in),
    .period(period0), .high_time(high0), .meas_valid(valid0),
    .meas_ready(meas_ready), .timeout(tmo0), .overrun(ovr0)
  );

  clk_period_monitor #(.CNT_W(CNT_W), .SYNC_STAGES(2), .TIMEOUT(TMO)) u_dut2 (
    .clk(clk), .rst(rst), .en(en), .sig_in(sig_in),
    .period(period2), .high_time(high2), .meas_valid(valid2),
    .meas_ready(meas_ready), .timeout(tmo2), .overrun(ovr2)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: timestamps of the interval start rather than a counter.
  // "cnt" at cycle n is n - m_ref.
  // ---------------------------------------------------------------------------
  typedef enum {M_IDLE, M_ARM, M_MEAS} mode_t;

  mode_t m_mode [2];
  int    m_ref  [2];
  int    m_hc   [2];
  int    m_per  [2];
  int    m_high [2];
  bit    m_valid[2];
  bit    m_tmo  [2];
  bit    m_ovr  [2];
  bit    m_prev [2];
  bit    m_dl   [2][4];
  int    n;

  logic [31:0] q0[$];
  logic [31:0] q1[$];

  function automatic int stages(input int i);
    return (i == 0) ? 0 : 2;
  endfunction

  task automatic model_reset(input int i);
    m_mode[i]  = M_IDLE;
    m_ref[i]   = 0;
    m_hc[i]    = 0;
    m_per[i]   = 0;
    m_high[i]  = 0;
    m_valid[i] = 1'b0;
    m_tmo[i]   = 1'b0;
    m_ovr[i]   = 1'b0;
    m_prev[i]  = 1'b1;
    for (int k = 0; k < 4; k++) m_dl[i][k] = 1'b0;
  endtask

  // Advance model i across the coming clock edge using the current inputs.
  task automatic model_step(input int i);
    bit s, rise, fall, result;
    int c;
    logic [31:0] exp_word;

    if (m_valid[i] && meas_ready) begin
      exp_word = {CNT_W'(m_per[i]), CNT_W'(m_high[i])};
      if (i == 0) q0.push_back(exp_word);
      else        q1.push_back(exp_word);
    end

    s    = (stages(i) == 0) ? sig_in : m_dl[i][stages(i)-1];
    rise = s && !m_prev[i];
    fall = !s && m_prev[i];

    if (rst) begin
      model_reset(i);
      return;
    end

    for (int k = 3; k > 0; k--) m_dl[i][k] = m_dl[i][k-1];
    m_dl[i][0] = sig_in;
    m_prev[i]  = s;

    if (!en) begin
      m_mode[i]  = M_IDLE;
      m_valid[i] = 1'b0;
      m_tmo[i]   = 1'b0;
      m_ovr[i]   = 1'b0;
      return;
    end

    result = 1'b0;
    c      = n - m_ref[i];
    case (m_mode[i])
      M_IDLE: begin
        m_mode[i] = M_ARM;
        m_ref[i]  = n + 1;
      end
      M_ARM: begin
        if (rise) begin
          m_mode[i] = M_MEAS;
          m_ref[i]  = n;
          m_tmo[i]  = 1'b0;
        end else if (c == TMO) begin
          m_tmo[i] = 1'b1;
          m_ref[i] = n + 1;
        end
      end
      M_MEAS: begin
        if (fall) m_hc[i] = c;
        if (rise) begin
          result   = 1'b1;
          m_ref[i] = n;
          m_tmo[i] = 1'b0;
        end else if (c == TMO) begin
          m_tmo[i]  = 1'b1;
          m_mode[i] = M_ARM;
          m_ref[i]  = n + 1;
        end
      end
      default: m_mode[i] = M_IDLE;
    endcase

    if (result) begin
      if (m_valid[i] && !meas_ready) m_ovr[i] = 1'b1;
      m_valid[i] = 1'b1;
      m_per[i]   = c;
      m_high[i]  = m_hc[i];
    end else if (m_valid[i] && meas_ready) begin
      m_valid[i] = 1'b0;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  bit checks_on = 1'b0;
  int ph = 0;

  task automatic check_outputs();
    check("dut0 outputs {period,high,valid,timeout,overrun}",
          {period0, high0, valid0, tmo0, ovr0},
          {CNT_W'(m_per[0]), CNT_W'(m_high[0]), m_valid[0], m_tmo[0], m_ovr[0]});
    check("dut2 outputs {period,high,valid,timeout,overrun}",
          {period2, high2, valid2, tmo2, ovr2},
          {CNT_W'(m_per[1]), CNT_W'(m_high[1]), m_valid[1], m_tmo[1], m_ovr[1]});
  endtask

  task automatic tick(input bit r, input bit e, input bit s, input bit rdy);
    @(negedge clk);
    if (checks_on) check_outputs();
    rst        = r;
    en         = e;
    sig_in     = s;
    meas_ready = rdy;
    model_step(0);
    model_step(1);
    n++;
  endtask

  // Wait until the last driven inputs have been clocked in.
  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  // rmode: 0 = ready high, 1 = ready low, 2 = random ready
  task automatic run_pattern(input int hi, input int lo, input int cycles, input int rmode);
    bit s, rdy;
    for (int i = 0; i < cycles; i++) begin
      s   = (ph % (hi + lo)) < hi;
      rdy = (rmode == 0) ? 1'b1 : (rmode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
      tick(1'b0, 1'b1, s, rdy);
      ph++;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scoreboard monitor: compare every handshake the DUTs present
  // ---------------------------------------------------------------------------
  initial begin
    logic [31:0] exp_word;
    forever begin
      @(negedge clk);
      #1;
      if (valid0 === 1'b1 && meas_ready === 1'b1) begin
        if (q0.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL dut0 result: unexpected handshake period=%0d high=%0d", period0, high0);
        end else begin
          exp_word = q0.pop_front();
          check("dut0 result {period,high}", {period0, high0}, exp_word);
        end
      end
      if (valid2 === 1'b1 && meas_ready === 1'b1) begin
        if (q1.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL dut2 result: unexpected handshake period=%0d high=%0d", period2, high2);
        end else begin
          exp_word = q1.pop_front();
          check("dut2 result {period,high}", {period2, high2}, exp_word);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    int r, hi, lo, len, rm;

    rst = 1'b1; en = 1'b0; sig_in = 1'b0; meas_ready = 1'b1;
    model_reset(0);
    model_reset(1);
    n = 0;

    tick(1'b1, 1'b0, 1'b0, 1'b1);
    checks_on = 1'b1;
    tick(1'b1, 1'b1, 1'b1, 1'b1);
    settle();
    check("reset dut0", {period0, high0, valid0, tmo0, ovr0}, 64'd0);
    check("reset dut2", {period2, high2, valid2, tmo2, ovr2}, 64'd0);

    // Divide-by-2
    ph = 0;
    run_pattern(1, 1, 40, 0);
    settle();
    check("div2 dut0 period/high", {period0, high0}, {16'd2, 16'd1});
    check("div2 dut2 period/high", {period2, high2}, {16'd2, 16'd1});

    // Divide-by-3, 1 high then 2 high
    run_pattern(1, 2, 30, 0);
    settle();
    check("div3 1,0,0 dut0", {period0, high0}, {16'd3, 16'd1});
    check("div3 1,0,0 dut2", {period2, high2}, {16'd3, 16'd1});
    run_pattern(2, 1, 30, 0);
    settle();
    check("div3 1,1,0 dut0", {period0, high0}, {16'd3, 16'd2});
    check("div3 1,1,0 dut2", {period2, high2}, {16'd3, 16'd2});

    // Consumer stalls for several results, then accepts
    run_pattern(2, 1, 9, 1);
    settle();
    check("stall overrun dut0", {valid0, ovr0}, 2'b11);
    check("stall overrun dut2", {valid2, ovr2}, 2'b11);
    run_pattern(2, 1, 12, 0);
    settle();
    check("overrun sticky dut0", ovr0, 1'b1);
    check("overrun sticky dut2", ovr2, 1'b1);

    // Missing signal: flush, then hold low past TIMEOUT
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 30; i++) tick(1'b0, 1'b1, 1'b0, 1'b1);
    settle();
    check("timeout dut0 {timeout,valid}", {tmo0, valid0}, 2'b10);
    check("timeout dut2 {timeout,valid}", {tmo2, valid2}, 2'b10);
    ph = 0;
    run_pattern(1, 1, 12, 0);
    settle();
    check("timeout cleared dut0", {tmo0, period0, high0}, {1'b0, 16'd2, 16'd1});
    check("timeout cleared dut2", {tmo2, period2, high2}, {1'b0, 16'd2, 16'd1});

    // Reset mid-measurement with the signal high
    run_pattern(2, 1, 10, 0);
    tick(1'b1, 1'b1, 1'b1, 1'b1);
    settle();
    check("mid reset dut0", {period0, high0, valid0, tmo0, ovr0}, 64'd0);
    check("mid reset dut2", {period2, high2, valid2, tmo2, ovr2}, 64'd0);
    ph = 1;
    run_pattern(2, 1, 20, 0);
    settle();
    check("after reset dut0", {period0, high0}, {16'd3, 16'd2});
    check("after reset dut2", {period2, high2}, {16'd3, 16'd2});

    // en dropped mid-measurement: valid flushed, values retained
    ph = 0;
    run_pattern(1, 1, 20, 2);
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    settle();
    check("en drop dut0", {valid0, period0, high0}, {1'b0, 16'd2, 16'd1});
    check("en drop dut2", {valid2, period2, high2}, {1'b0, 16'd2, 16'd1});

    // Randomised segments
    for (int seg = 0; seg < 60; seg++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        len = $urandom_range(1, 4);
        for (int i = 0; i < len; i++) tick(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b1);
      end else if (r == 1) begin
        tick(1'b1, 1'b1, 1'($urandom_range(0, 1)), 1'b1);
      end else if (r == 2) begin
        for (int i = 0; i < 25; i++) tick(1'b0, 1'b1, 1'b0, 1'($urandom_range(0, 1)));
      end else begin
        hi  = $urandom_range(1, 12);
        lo  = $urandom_range(1, 12);
        len = $urandom_range(10, 60);
        rm  = $urandom_range(0, 2);
        run_pattern(hi, lo, len, rm);
      end
    end

    // Drain with the consumer ready
    ph = 0;
    run_pattern(1, 1, 10, 0);
    @(negedge clk);
    #2;
    check("dut0 scoreboard drained", 64'(q0.size()), 64'd0);
    check("dut2 scoreboard drained", 64'(q1.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
